breath_seq_ctrl: RTL

Sequencer that runs a single shared breathing-PWM engine across `LED_NUM` LEDs as a "running breath" pattern. Each LED in turn ramps from dark to full brightness, then back to dark, before the next LED starts. Start, stop, hold and loop controls come from the board-level key/command logic. It sits between that control logic and the LED pins, and replaces per-LED free-running breath counters.

---
 rtl/breath_pkg.sv | 27 ++
 rtl/breath_seq_ctrl_if.sv | 39 +++
 rtl/breath_timebase.sv | 80 ++++++++
 rtl/breath_seq_ctrl.sv | 131 +++++++++++++
 4 files changed

// File: rtl/breath_pkg.sv
// Shared definitions for the running-breath LED sequencer.
//   state_e          : sequencer state (IDLE, RISE, FALL)
//   DEF_*            : default timing for a 50 MHz system clock
//   cnt_w / idx_w    : counter and channel-index width helpers
package breath_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RISE = 2'd1,
    FALL = 2'd2
  } state_e;

  localparam int unsigned DEF_LED_NUM      = 4;
  localparam int unsigned DEF_CNT_TICK_MAX = 100;   // 2 us tick at 50 MHz
  localparam int unsigned DEF_DUTY_MAX     = 1000;

  // Width of a counter that runs 0..max_val-1 (never narrower than 1 bit).
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val <= 1) ? 1 : $clog2(max_val);
  endfunction

  // Width of a channel index selecting one of n_ch channels.
  function automatic int unsigned idx_w(input int unsigned n_ch);
    return (n_ch <= 1) ? 1 : $clog2(n_ch);
  endfunction

endpackage

// File: rtl/breath_seq_ctrl_if.sv
// Control/status bundle between the board key/command logic and the
// breath sequencer.
//   start   : one-cycle pulse, begin a sequence from channel 0 when idle
//   stop    : one-cycle pulse, abort any sequence
//   hold    : level, freeze the sequence
//   loop_en : level, wrap to channel 0 after the last channel
//   led     : LED drive, active-high
//   busy    : sequence in progress
//   ch_idx  : active channel
//   done    : one-cycle pulse on natural completion
// master = command side, slave = sequencer side.
interface breath_seq_ctrl_if
  import breath_pkg::*;
#(
  parameter int unsigned LED_NUM = DEF_LED_NUM
) ();

  localparam int unsigned IDX_W = idx_w(LED_NUM);

  logic               start;
  logic               stop;
  logic               hold;
  logic               loop_en;
  logic [LED_NUM-1:0] led;
  logic               busy;
  logic [IDX_W-1:0]   ch_idx;
  logic               done;

  modport master (
    output start, stop, hold, loop_en,
    input  led, busy, ch_idx, done
  );

  modport slave (
    input  start, stop, hold, loop_en,
    output led, busy, ch_idx, done
  );

endinterface

// File: rtl/breath_timebase.sv
// Tick / PWM-frame / breath-step counter chain for the breath sequencer.
//   clk, rst_n : clock, asynchronous active-low reset
//   run        : counters advance while high, sit at 0 while low
//   hold       : freeze all counters (and suppress events)
//   clr        : synchronous clear to 0, overrides hold
//   tick_end, frame_end, step_end : end-of-period events (only when advancing)
//   cnt_frame  : position inside the current PWM frame (in ticks)
//   cnt_step   : brightness step inside the current half-breath
module breath_timebase
  import breath_pkg::*;
#(
  parameter int unsigned CNT_TICK_MAX = DEF_CNT_TICK_MAX,
  parameter int unsigned DUTY_MAX     = DEF_DUTY_MAX
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       run,
  input  logic                       hold,
  input  logic                       clr,
  output logic                       tick_end,
  output logic                       frame_end,
  output logic                       step_end,
  output logic [cnt_w(DUTY_MAX)-1:0] cnt_frame,
  output logic [cnt_w(DUTY_MAX)-1:0] cnt_step
);

  localparam int unsigned TICK_W = cnt_w(CNT_TICK_MAX);
  localparam int unsigned DUTY_W = cnt_w(DUTY_MAX);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CNT_TICK_MAX - 1);
  localparam logic [DUTY_W-1:0] DUTY_LAST = DUTY_W'(DUTY_MAX - 1);

  logic [TICK_W-1:0] cnt_tick_q,  cnt_tick_d;
  logic [DUTY_W-1:0] cnt_frame_q, cnt_frame_d;
  logic [DUTY_W-1:0] cnt_step_q,  cnt_step_d;
  logic              adv;

  always_comb begin
    // Events are qualified with adv so a held or cleared cycle never
    // produces one; a deferred event fires on the first free cycle.
    adv       = run & ~hold & ~clr;
    tick_end  = adv & (cnt_tick_q == TICK_LAST);
    frame_end = tick_end & (cnt_frame_q == DUTY_LAST);
    step_end  = frame_end & (cnt_step_q == DUTY_LAST);

    cnt_tick_d  = cnt_tick_q;
    cnt_frame_d = cnt_frame_q;
    cnt_step_d  = cnt_step_q;

    if (clr || !run) begin
      cnt_tick_d  = '0;
      cnt_frame_d = '0;
      cnt_step_d  = '0;
    end else if (adv) begin
      cnt_tick_d = tick_end ? '0 : cnt_tick_q + 1'b1;
      if (tick_end) begin
        cnt_frame_d = frame_end ? '0 : cnt_frame_q + 1'b1;
      end
      if (frame_end) begin
        cnt_step_d = step_end ? '0 : cnt_step_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_tick_q  <= '0;
      cnt_frame_q <= '0;
      cnt_step_q  <= '0;
    end else begin
      cnt_tick_q  <= cnt_tick_d;
      cnt_frame_q <= cnt_frame_d;
      cnt_step_q  <= cnt_step_d;
    end
  end

  assign cnt_frame = cnt_frame_q;
  assign cnt_step  = cnt_step_q;

endmodule

// File: rtl/breath_seq_ctrl.sv
// Running-breath sequencer: one shared breathing-PWM timebase walks across
// LED_NUM channels; each channel ramps dark -> full -> dark, then the next
// channel starts.
//   sys_clk    : system clock, rising edge
//   sys_rst_n  : asynchronous active-low reset
//   io (slave) : start/stop/hold/loop_en in; led/busy/ch_idx/done out
module breath_seq_ctrl
  import breath_pkg::*;
#(
  parameter int unsigned LED_NUM      = DEF_LED_NUM,
  parameter int unsigned CNT_TICK_MAX = DEF_CNT_TICK_MAX,
  parameter int unsigned DUTY_MAX     = DEF_DUTY_MAX
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  breath_seq_ctrl_if.slave io
);

  localparam int unsigned IDX_W  = idx_w(LED_NUM);
  localparam int unsigned DUTY_W = cnt_w(DUTY_MAX);

  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(LED_NUM - 1);
  localparam logic [DUTY_W-1:0] DUTY_TOP = DUTY_W'(DUTY_MAX - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ch_q,    ch_d;
  logic [LED_NUM-1:0] led_q,   led_d;
  logic               done_q,  done_d;

  logic              run;
  logic              tick_end, frame_end, step_end;
  logic [DUTY_W-1:0] cnt_frame, cnt_step, duty;
  logic              unused_events;

  assign run = (state_q != IDLE);

  breath_timebase #(
    .CNT_TICK_MAX (CNT_TICK_MAX),
    .DUTY_MAX     (DUTY_MAX)
  ) u_timebase (
    .clk       (sys_clk),
    .rst_n     (sys_rst_n),
    .run       (run),
    .hold      (io.hold),
    .clr       (io.stop),
    .tick_end  (tick_end),
    .frame_end (frame_end),
    .step_end  (step_end),
    .cnt_frame (cnt_frame),
    .cnt_step  (cnt_step)
  );

  // Only the half-breath boundary steers the FSM.
  assign unused_events = tick_end ^ frame_end;

  // Falling half mirrors the rising ramp; DUTY_TOP >= cnt_step always.
  always_comb begin
    duty = (state_q == FALL) ? (DUTY_TOP - cnt_step) : cnt_step;
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    led_d   = led_q;
    done_d  = 1'b0;

    if (io.stop) begin
      state_d = IDLE;
      ch_d    = '0;
      led_d   = '0;
    end else if (!io.hold) begin
      // led reflects the counter state of this cycle, one cycle later.
      for (int unsigned i = 0; i < LED_NUM; i++) begin
        led_d[i] = run && (ch_q == IDX_W'(i)) && (cnt_frame < duty);
      end

      case (state_q)
        IDLE: begin
          if (io.start) begin
            state_d = RISE;
            ch_d    = '0;
          end
        end
        RISE: begin
          if (step_end) begin
            state_d = FALL;
          end
        end
        FALL: begin
          if (step_end) begin
            if (ch_q != IDX_LAST) begin
              state_d = RISE;
              ch_d    = ch_q + 1'b1;
            end else if (io.loop_en) begin
              state_d = RISE;
              ch_d    = '0;
            end else begin
              state_d = IDLE;
              ch_d    = '0;
              done_d  = 1'b1;
            end
          end
        end
        default: begin
          state_d = IDLE;
          ch_d    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      ch_q    <= '0;
      led_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      led_q   <= led_d;
      done_q  <= done_d;
    end
  end

  assign io.led    = led_q;
  assign io.busy   = run;
  assign io.ch_idx = ch_q;
  assign io.done   = done_q;

endmodule
